reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Board-level reset controller that sits between the raw asynchronous reset, PLL lock and software reset request, and the per-domain synchronous resets of the design. It synchronizes its own reset release, waits out a power-on delay and PLL lock, then releases NUM_DOMAINS reset outputs in order, domain 0 first, with a fixed stagger. On a software request, or on lock loss when enabled, it re-asserts all domain resets together and re-runs the release sequence.

## Interface
- NUM_DOMAINS, 4: number of reset outputs, 1..16.
- POR_CYCLES, 1024: power-on wait after internal reset release, >=1.
- STAGGER_CYCLES, 16: cycles between release of domain k and domain k+1, >=1.
- HOLD_CYCLES, 32: minimum reset-assert time on re-sequence, >=1.
- clk  in  1  system clock.
- rst_async_n  in  1  reset, asynchronous, active-low; clock clk.
- pll_locked  in  1  PLL lock, asynchronous to clk; 2-flop synchronized internally (locked_s).
- sw_rst_req  in  1  synchronous single-cycle software reset request.
- rst_n_out  out  NUM_DOMAINS  per-domain active-low resets, registered, glitch-free.
- seq_done  out  1  high when all domains are released (RUN state).
- seq_state  out  3  current state encoding, for debug and status registers.

## Operation
- Internal reset: 2-stage synchronizer on rst_async_n. Asserts asynchronously, deasserts on the 2nd rising clk edge after rst_async_n rises. T0 is the first edge with internal reset high.
- rst_async_n low at any time: all rst_n_out=0, seq_done=0, seq_state=POR_WAIT, counters=0, sync flops=0. Asynchronous; no clock required.
- States (seq_state): POR_WAIT=0, LOCK_WAIT=1, RELEASE=2, RUN=3, HOLD=4. Codes 5-7 are unreachable and recover to HOLD.
- POR_WAIT: count POR_CYCLES, then go to LOCK_WAIT. Ignore sw_rst_req and pll_locked.
- LOCK_WAIT: stay while locked_s=0. When locked_s=1, go to RELEASE and set rst_n_out[0]=1 on the same edge. Ignore sw_rst_req.
- RELEASE: set rst_n_out[k]=1 STAGGER_CYCLES*k cycles after rst_n_out[0]. Once rst_n_out[NUM_DOMAINS-1]=1, enter RUN on the next edge with seq_done=1. Released bits stay 1.
- RUN: hold all outputs released.
- Re-sequence trigger: sw_rst_req=1 in RELEASE or RUN, or lock loss (see Configuration). On the next edge: all rst_n_out=0, seq_done=0, enter HOLD, clear the counter.
- HOLD: count HOLD_CYCLES, then go to LOCK_WAIT. Further triggers in HOLD are ignored and do not restart the count.
- sw_rst_req and lock loss in the same cycle: single HOLD entry.
- NUM_DOMAINS=1: RELEASE lasts one cycle, then RUN.
- Counter width is $clog2 of max(POR_CYCLES, STAGGER_CYCLES*(NUM_DOMAINS-1), HOLD_CYCLES)+1. The counter never wraps; it is cleared on every state entry.

## Timing
- With pll_locked stable high: rst_n_out[0] rises at T0+POR_CYCLES+1, rst_n_out[k] at T0+POR_CYCLES+1+k*STAGGER_CYCLES, and seq_done one edge after the last domain.
- pll_locked to locked_s latency: 2 edges.
- Trigger sampled at edge E: outputs low after E. With locked_s=1, rst_n_out[0] rises at E+HOLD_CYCLES+1.
- All outputs are flop-driven; no combinational path from any input to any output.

## Configuration
- RESET_SEQ_LOCK_MON_EN defined: locked_s=0 in RELEASE or RUN is a re-sequence trigger. Outputs go low on the edge after locked_s falls, at most 3 edges after pll_locked falls. After HOLD, LOCK_WAIT waits for relock.
- Undefined: pll_locked is examined only in LOCK_WAIT. Lock loss after release is ignored, and the lock synchronizer is still present.

## Test plan
All scenarios use NUM_DOMAINS=3, POR_CYCLES=8, STAGGER_CYCLES=4, HOLD_CYCLES=5.
- Cold start, pll_locked=1 throughout -> rst_n_out bits rise at T0+9, T0+13, T0+17; seq_done=1 at T0+18; seq_state 0->1->2->3.
- pll_locked rises at T0+30 -> seq_state=1 until locked_s=1; rst_n_out[0] rises 3 edges after pll_locked (2 sync edges + 1).
- sw_rst_req pulse at edge E in RUN -> rst_n_out=000 and seq_done=0 after E; bit 0 rises at E+6, bit 2 at E+14. A second pulse at E+2 has no effect.
- sw_rst_req during POR_WAIT or LOCK_WAIT -> ignored, sequence timing unchanged. Pulse during RELEASE after bit 0 release -> all bits low next edge, HOLD entered.
- With RESET_SEQ_LOCK_MON_EN, drop pll_locked in RUN -> outputs 000 within 3 edges, then HOLD; re-lock -> normal stagger. Without the macro -> outputs stay 111.
- rst_async_n pulsed low mid-RELEASE -> outputs 000 and seq_done=0 immediately without a clock edge; full sequence restarts from POR_WAIT.

Source files
------------

// File: rtl/reset_sequencer.sv
// Board reset sequencer: synchronizes reset release, waits POR and PLL lock, then
// releases per-domain resets in a fixed stagger. Lock-loss monitor: RESET_SEQ_LOCK_MON_EN.

module reset_seq_domain (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic set,
   output logic rst_n_out
);
   logic rel_q, rel_d;

   always_comb begin
      rel_d = rel_q;
      if (clr)      rel_d = 1'b0;
      else if (set) rel_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) rel_q <= 1'b0;
      else        rel_q <= rel_d;

   assign rst_n_out = rel_q;
endmodule

module reset_sequencer #(
   parameter int NUM_DOMAINS    = 4,
   parameter int POR_CYCLES     = 1024,
   parameter int STAGGER_CYCLES = 16,
   parameter int HOLD_CYCLES    = 32
) (
   input  logic                   clk,
   input  logic                   rst_async_n,
   input  logic                   pll_locked,
   input  logic                   sw_rst_req,
   output logic [NUM_DOMAINS-1:0] rst_n_out,
   output logic                   seq_done,
   output logic [2:0]             seq_state
);
   localparam int REL_SPAN = STAGGER_CYCLES * (NUM_DOMAINS - 1);
   localparam int MAX_A    = (POR_CYCLES > REL_SPAN) ? POR_CYCLES : REL_SPAN;
   localparam int CNT_MAX  = (MAX_A > HOLD_CYCLES) ? MAX_A : HOLD_CYCLES;
   localparam int CNT_W    = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {
      POR_WAIT  = 3'd0,
      LOCK_WAIT = 3'd1,
      RELEASE   = 3'd2,
      RUN       = 3'd3,
      HOLD      = 3'd4
   } state_e;

   logic [1:0]             rst_sync_q, rst_sync_d;
   logic [1:0]             lock_sync_q, lock_sync_d;
   logic                   rst_int_n;
   logic                   locked_s;
   logic                   trig;
   logic                   go_hold;
   logic [NUM_DOMAINS-1:0] lane_set;
   logic [CNT_W:0]         cnt_inc;
   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   done_q, done_d;

   // Both synchronizers clear straight from the pin so assertion needs no clock.
   always_comb begin
      rst_sync_d  = {rst_sync_q[0], 1'b1};
      lock_sync_d = {lock_sync_q[0], pll_locked};
   end

   always_ff @(posedge clk or negedge rst_async_n)
      if (!rst_async_n) begin
         rst_sync_q  <= '0;
         lock_sync_q <= '0;
      end else begin
         rst_sync_q  <= rst_sync_d;
         lock_sync_q <= lock_sync_d;
      end

   assign rst_int_n = rst_sync_q[1];
   assign locked_s  = lock_sync_q[1];

`ifdef RESET_SEQ_LOCK_MON_EN
   assign trig = sw_rst_req | ~locked_s;
`else
   assign trig = sw_rst_req;
`endif

   assign cnt_inc = {1'b0, cnt_q} + 1'b1;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      go_hold  = 1'b0;
      lane_set = '0;
      case (state_q)
         POR_WAIT:
            if (cnt_q == CNT_W'(POR_CYCLES)) begin
               state_d = LOCK_WAIT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         LOCK_WAIT:
            if (locked_s) begin
               state_d     = RELEASE;
               cnt_d       = '0;
               lane_set[0] = 1'b1;
            end
         RELEASE:
            if (trig) begin
               go_hold = 1'b1;
            end else if (rst_n_out[NUM_DOMAINS-1]) begin
               state_d = RUN;
               cnt_d   = '0;
            end else begin
               // Domain k opens on the edge where the count reaches k*STAGGER_CYCLES.
               cnt_d = cnt_q + 1'b1;
               for (int k = 1; k < NUM_DOMAINS; k++)
                  lane_set[k] = (cnt_inc >= (CNT_W+1)'(STAGGER_CYCLES * k));
            end
         RUN:
            if (trig) go_hold = 1'b1;
         HOLD:
            if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
               state_d = LOCK_WAIT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         default: go_hold = 1'b1;
      endcase
      if (go_hold) begin
         state_d = HOLD;
         cnt_d   = '0;
      end
      done_d = (state_d == RUN);
   end

   always_ff @(posedge clk or negedge rst_int_n)
      if (!rst_int_n) begin
         state_q <= POR_WAIT;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end

   for (genvar k = 0; k < NUM_DOMAINS; k++) begin : g_dom
      reset_seq_domain u_dom (
         .clk       (clk),
         .rst_n     (rst_int_n),
         .clr       (go_hold),
         .set       (lane_set[k]),
         .rst_n_out (rst_n_out[k])
      );
   end

   assign seq_done  = done_q;
   assign seq_state = state_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer (3 domains, POR 8, stagger 4, hold 5).
module tb_reset_sequencer;
   logic       clk;
   logic       rst_async_n;
   logic       pll_locked;
   logic       sw_rst_req;
   logic [2:0] rst_n_out;
   logic       seq_done;
   logic [2:0] seq_state;

   int n_err = 0;
   int n_chk = 0;
   int t_now = 0;

   reset_sequencer #(
      .NUM_DOMAINS(3), .POR_CYCLES(8), .STAGGER_CYCLES(4), .HOLD_CYCLES(5)
   ) dut (
      .clk         (clk),
      .rst_async_n (rst_async_n),
      .pll_locked  (pll_locked),
      .sw_rst_req  (sw_rst_req),
      .rst_n_out   (rst_n_out),
      .seq_done    (seq_done),
      .seq_state   (seq_state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // t_now counts edges relative to T0; sampling is 1 time unit after the edge.
   task automatic adv_to(input int t);
      while (t_now < t) begin
         @(posedge clk);
         #1;
         t_now++;
      end
   endtask

   task automatic chk(input string tag, input logic [2:0] e_rst, input logic e_done,
                      input logic [2:0] e_state);
      n_chk++;
      assert (rst_n_out === e_rst) else begin
         n_err++;
         $error("FAIL %s rst_n_out: observed %b expected %b", tag, rst_n_out, e_rst);
      end
      n_chk++;
      assert (seq_done === e_done) else begin
         n_err++;
         $error("FAIL %s seq_done: observed %b expected %b", tag, seq_done, e_done);
      end
      n_chk++;
      assert (seq_state === e_state) else begin
         n_err++;
         $error("FAIL %s seq_state: observed %0d expected %0d", tag, seq_state, e_state);
      end
   endtask

   task automatic release_reset();
      @(posedge clk);
      #1;
      rst_async_n = 1'b1;
      t_now = -3;
   endtask

   initial begin
      rst_async_n = 1'b0;
      pll_locked  = 1'b1;
      sw_rst_req  = 1'b0;
      #2;
      chk("reset_noclk", 3'b000, 1'b0, 3'd0);
      @(posedge clk);
      #1;
      chk("reset_clk", 3'b000, 1'b0, 3'd0);

      // Cold start, lock stable
      release_reset();
      adv_to(7);  chk("por_t7",    3'b000, 1'b0, 3'd0);
      adv_to(8);  chk("lockw_t8",  3'b000, 1'b0, 3'd1);
      adv_to(9);  chk("rel0_t9",   3'b001, 1'b0, 3'd2);
      adv_to(12); chk("rel0_t12",  3'b001, 1'b0, 3'd2);
      adv_to(13); chk("rel1_t13",  3'b011, 1'b0, 3'd2);
      adv_to(16); chk("rel1_t16",  3'b011, 1'b0, 3'd2);
      adv_to(17); chk("rel2_t17",  3'b111, 1'b0, 3'd2);
      adv_to(18); chk("run_t18",   3'b111, 1'b1, 3'd3);

      // Software request in RUN sampled at E=21, second pulse at E+2 ignored
      adv_to(20); sw_rst_req = 1'b1;
      adv_to(21); sw_rst_req = 1'b0; chk("sw_hold_E", 3'b000, 1'b0, 3'd4);
      adv_to(22); sw_rst_req = 1'b1;
      adv_to(23); sw_rst_req = 1'b0; chk("sw_2nd_E2", 3'b000, 1'b0, 3'd4);
      adv_to(25); chk("sw_hold_E4", 3'b000, 1'b0, 3'd4);
      adv_to(26); chk("sw_lockw_E5", 3'b000, 1'b0, 3'd1);
      adv_to(27); chk("sw_rel0_E6",  3'b001, 1'b0, 3'd2);
      adv_to(31); chk("sw_rel1_E10", 3'b011, 1'b0, 3'd2);
      adv_to(35); chk("sw_rel2_E14", 3'b111, 1'b0, 3'd2);
      adv_to(36); chk("sw_run_E15",  3'b111, 1'b1, 3'd3);

      // Re-sequence, then a request during RELEASE after bit 0 is out
      adv_to(40); sw_rst_req = 1'b1;
      adv_to(41); sw_rst_req = 1'b0; chk("sw2_hold", 3'b000, 1'b0, 3'd4);
      adv_to(47); chk("sw2_rel0", 3'b001, 1'b0, 3'd2);
      adv_to(48); sw_rst_req = 1'b1;
      adv_to(49); sw_rst_req = 1'b0; chk("relreq_hold", 3'b000, 1'b0, 3'd4);
      adv_to(55); chk("relreq_rel0", 3'b001, 1'b0, 3'd2);

      // Asynchronous reset mid-RELEASE takes effect with no clock edge
      adv_to(56); chk("pre_async", 3'b001, 1'b0, 3'd2);
      rst_async_n = 1'b0;
      pll_locked  = 1'b0;
      #2;
      chk("async_noclk", 3'b000, 1'b0, 3'd0);

      // Restart with late lock; requests in POR_WAIT/LOCK_WAIT ignored
      release_reset();
      adv_to(3);  sw_rst_req = 1'b1;
      adv_to(4);  sw_rst_req = 1'b0; chk("por_req_ign", 3'b000, 1'b0, 3'd0);
      adv_to(7);  chk("late_por_t7",  3'b000, 1'b0, 3'd0);
      adv_to(8);  chk("late_lockw_t8", 3'b000, 1'b0, 3'd1);
      adv_to(12); sw_rst_req = 1'b1;
      adv_to(13); sw_rst_req = 1'b0; chk("lockw_req_ign", 3'b000, 1'b0, 3'd1);
      adv_to(29); pll_locked = 1'b1;
      adv_to(31); chk("lock_sync_t31", 3'b000, 1'b0, 3'd1);
      adv_to(32); chk("lock_rel0_t32", 3'b001, 1'b0, 3'd2);
      adv_to(36); chk("lock_rel1_t36", 3'b011, 1'b0, 3'd2);
      adv_to(40); chk("lock_rel2_t40", 3'b111, 1'b0, 3'd2);
      adv_to(41); chk("lock_run_t41",  3'b111, 1'b1, 3'd3);

      // Lock loss in RUN, sampled at edge 46
      adv_to(45); pll_locked = 1'b0;
`ifdef RESET_SEQ_LOCK_MON_EN
      adv_to(47); chk("ll_t47",    3'b111, 1'b1, 3'd3);
      adv_to(48); chk("ll_hold",   3'b000, 1'b0, 3'd4);
      adv_to(53); chk("ll_lockw",  3'b000, 1'b0, 3'd1);
      adv_to(54); pll_locked = 1'b1;
      adv_to(56); chk("ll_wait",   3'b000, 1'b0, 3'd1);
      adv_to(57); chk("ll_rel0",   3'b001, 1'b0, 3'd2);
      adv_to(65); chk("ll_rel2",   3'b111, 1'b0, 3'd2);
      adv_to(66); chk("ll_run",    3'b111, 1'b1, 3'd3);
`else
      adv_to(48); chk("ll_ign_t48", 3'b111, 1'b1, 3'd3);
      adv_to(52); chk("ll_ign_t52", 3'b111, 1'b1, 3'd3);
      pll_locked = 1'b1;
      adv_to(56); chk("ll_ign_t56", 3'b111, 1'b1, 3'd3);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
